// File: rtl/wb_arbiter.sv
// Write-back arbiter: one pending slot each for ALU, JAL link and load return,
// merged onto a single register-file write port with age-based grant.
module wb_arbiter #(
   parameter int LINK_REG = 31,
   parameter int WAIT_SAT = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               alu_valid,
   input  logic [4:0]         alu_rd,
   input  logic signed [31:0] alu_data,
   input  logic               jal_valid,
   input  logic signed [31:0] jal_pc_plus1,
   input  logic               mem_valid,
   input  logic [4:0]         mem_rd,
   input  logic signed [31:0] mem_data,
   output logic               alu_ready,
   output logic               jal_ready,
   output logic               mem_ready,
   output logic               rf_we,
   output logic [4:0]         rf_waddr,
   output logic signed [31:0] rf_wdata,
   output logic               wb_busy
);

   localparam int         N_SRC    = 3;
   localparam logic [4:0] LINK_RD  = 5'(LINK_REG);
   localparam logic [2:0] WAIT_MAX = 3'(WAIT_SAT);

   // slot index order doubles as tie priority: the highest index wins ties
   localparam int SRC_ALU = 0;
   localparam int SRC_JAL = 1;
   localparam int SRC_MEM = 2;

   logic [N_SRC-1:0]   pend_q, pend_d;
   logic [4:0]         rd_q       [N_SRC];
   logic [4:0]         rd_d       [N_SRC];
   logic signed [31:0] data_q     [N_SRC];
   logic signed [31:0] data_d     [N_SRC];
   logic [2:0]         wait_cnt_q [N_SRC];
   logic [2:0]         wait_cnt_d [N_SRC];

   logic [N_SRC-1:0]   req_valid;
   logic [4:0]         req_rd     [N_SRC];
   logic signed [31:0] req_data   [N_SRC];
   logic [N_SRC-1:0]   grant;
   logic [N_SRC-1:0]   ready;
   logic               gnt_any;
   logic [1:0]         gnt_idx;
   logic [2:0]         best_wait;

   always_comb begin
      req_valid          = '0;
      req_valid[SRC_ALU] = alu_valid;
      req_valid[SRC_JAL] = jal_valid;
      req_valid[SRC_MEM] = mem_valid;
      req_rd[SRC_ALU]    = alu_rd;
      req_rd[SRC_JAL]    = LINK_RD;
      req_rd[SRC_MEM]    = mem_rd;
      req_data[SRC_ALU]  = alu_data;
      req_data[SRC_JAL]  = jal_pc_plus1;
      req_data[SRC_MEM]  = mem_data;
   end

   // Oldest pending slot wins; '>=' lets later slots take ties.
   always_comb begin
      gnt_any   = 1'b0;
      gnt_idx   = 2'd0;
      best_wait = 3'd0;
      grant     = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (pend_q[i] && (!gnt_any || wait_cnt_q[i] >= best_wait)) begin
            gnt_any   = 1'b1;
            gnt_idx   = 2'(i);
            best_wait = wait_cnt_q[i];
         end
      end
      if (gnt_any) begin
         grant[gnt_idx] = 1'b1;
      end
   end

   assign ready     = ~pend_q | grant;
   assign alu_ready = ready[SRC_ALU];
   assign jal_ready = ready[SRC_JAL];
   assign mem_ready = ready[SRC_MEM];
   assign wb_busy   = |pend_q;

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = 32'sd0;
      if (gnt_any) begin
         rf_we    = (rd_q[gnt_idx] != 5'd0);
         rf_waddr = rd_q[gnt_idx];
         rf_wdata = data_q[gnt_idx];
      end
   end

   always_comb begin
      pend_d     = pend_q;
      rd_d       = rd_q;
      data_d     = data_q;
      wait_cnt_d = wait_cnt_q;
      for (int i = 0; i < N_SRC; i++) begin
         if (req_valid[i] && ready[i]) begin
            pend_d[i]     = 1'b1;
            rd_d[i]       = req_rd[i];
            data_d[i]     = req_data[i];
            wait_cnt_d[i] = 3'd0;
         end else if (grant[i]) begin
            pend_d[i]     = 1'b0;
            wait_cnt_d[i] = 3'd0;
         end else if (pend_q[i] && wait_cnt_q[i] < WAIT_MAX) begin
            wait_cnt_d[i] = wait_cnt_q[i] + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q     <= '0;
         rd_q       <= '{default: '0};
         data_q     <= '{default: '0};
         wait_cnt_q <= '{default: '0};
      end else begin
         pend_q     <= pend_d;
         rd_q       <= rd_d;
         data_q     <= data_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued as stimulus is
// driven and popped by a monitor whenever the DUT asserts rf_we.
module tb_wb_arbiter;

   logic               clk = 1'b0;
   logic               reset;
   logic               alu_valid, jal_valid, mem_valid;
   logic [4:0]         alu_rd, mem_rd;
   logic signed [31:0] alu_data, jal_pc_plus1, mem_data;
   logic               alu_ready, jal_ready, mem_ready;
   logic               rf_we;
   logic [4:0]         rf_waddr;
   logic signed [31:0] rf_wdata;
   logic               wb_busy;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.LINK_REG(31), .WAIT_SAT(7)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .jal_valid(jal_valid), .jal_pc_plus1(jal_pc_plus1),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
      .alu_ready(alu_ready), .jal_ready(jal_ready), .mem_ready(mem_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .wb_busy(wb_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data);
      wr_t w;
      w.addr = addr;
      w.data = data;
      sb.push_back(w);
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         n_tests++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_write: observed addr %0d data %0h expected no write",
                   rf_waddr, rf_wdata);
         end
         if (sb.size() != 0) begin
            wr_t w;
            w = sb.pop_front();
            check("sb_waddr", 32'(rf_waddr), 32'(w.addr));
            check("sb_wdata", rf_wdata, w.data);
         end
      end
   end

   initial begin
      reset = 1'b1;
      alu_valid = 1'b0; jal_valid = 1'b0; mem_valid = 1'b0;
      alu_rd = '0; mem_rd = '0;
      alu_data = '0; jal_pc_plus1 = '0; mem_data = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // after reset
      @(negedge clk);
      check("rst_we",        32'(rf_we),     32'd0);
      check("rst_waddr",     32'(rf_waddr),  32'd0);
      check("rst_wdata",     rf_wdata,       32'd0);
      check("rst_busy",      32'(wb_busy),   32'd0);
      check("rst_alu_ready", 32'(alu_ready), 32'd1);
      check("rst_jal_ready", 32'(jal_ready), 32'd1);
      check("rst_mem_ready", 32'(mem_ready), 32'd1);

      // single ALU write
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
      expect_wr(5'd5, 32'h0000_00AA);
      edge_step();
      alu_valid = 1'b0;
      @(negedge clk);
      check("single_we",   32'(rf_we),   32'd1);
      check("single_busy", 32'(wb_busy), 32'd1);
      edge_step();
      @(negedge clk);
      check("single_busy_after", 32'(wb_busy), 32'd0);
      check("single_we_after",   32'(rf_we),   32'd0);

      // three sources on the same edge: MEM, JAL, ALU
      mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
      jal_valid = 1'b1; jal_pc_plus1 = 32'h40;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h22;
      expect_wr(5'd3, 32'h11);
      expect_wr(5'd31, 32'h40);
      expect_wr(5'd7, 32'h22);
      edge_step();
      mem_valid = 1'b0; jal_valid = 1'b0; alu_valid = 1'b0;
      @(negedge clk);
      check("three_c1_addr",  32'(rf_waddr),  32'd3);
      check("three_c1_jal_r", 32'(jal_ready), 32'd0);
      check("three_c1_alu_r", 32'(alu_ready), 32'd0);
      check("three_c1_mem_r", 32'(mem_ready), 32'd1);
      edge_step();
      @(negedge clk);
      check("three_c2_we",   32'(rf_we),    32'd1);
      check("three_c2_addr", 32'(rf_waddr), 32'd31);
      edge_step();
      @(negedge clk);
      check("three_c3_addr", 32'(rf_waddr), 32'd7);
      edge_step();
      @(negedge clk);
      check("three_idle_busy", 32'(wb_busy), 32'd0);

      // anti-starvation: MEM and JAL present every cycle
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h1234;
      mem_valid = 1'b1; mem_rd = 5'd1;  mem_data = 32'h100;
      jal_valid = 1'b1; jal_pc_plus1 = 32'h200;
      expect_wr(5'd1,  32'h100);
      expect_wr(5'd31, 32'h200);
      expect_wr(5'd10, 32'h1234);
      expect_wr(5'd1,  32'h101);
      expect_wr(5'd31, 32'h202);
      edge_step();
      alu_valid = 1'b0; mem_data = 32'h101; jal_pc_plus1 = 32'h201;
      edge_step();
      mem_data = 32'h102; jal_pc_plus1 = 32'h202;
      edge_step();
      mem_valid = 1'b0; jal_valid = 1'b0;
      @(negedge clk);
      check("starve_alu_third", 32'(rf_waddr),  32'd10);
      check("starve_mem_stall", 32'(mem_ready), 32'd0);
      repeat (3) edge_step();
      @(negedge clk);
      check("starve_idle_busy", 32'(wb_busy), 32'd0);

      // rd = 0: granted and retired, no write
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
      #1;
      check("rd0_ready_pre", 32'(alu_ready), 32'd1);
      edge_step();
      alu_valid = 1'b0;
      @(negedge clk);
      check("rd0_we",        32'(rf_we),     32'd0);
      check("rd0_busy",      32'(wb_busy),   32'd1);
      check("rd0_ready",     32'(alu_ready), 32'd1);
      edge_step();
      @(negedge clk);
      check("rd0_busy_after", 32'(wb_busy), 32'd0);

      // same rd, oldest first, ALU blocked by JAL
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1;
      jal_valid = 1'b1; jal_pc_plus1 = 32'h8000_0050;
      expect_wr(5'd31, 32'h8000_0050);
      expect_wr(5'd9, 32'h1);
      expect_wr(5'd9, 32'h2);
      edge_step();
      alu_valid = 1'b0; jal_valid = 1'b0;
      mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h2;
      @(negedge clk);
      check("samerd_jal_first", 32'(rf_waddr), 32'd31);
      edge_step();
      mem_valid = 1'b0;
      @(negedge clk);
      check("samerd_first_data", rf_wdata, 32'h1);
      edge_step();
      @(negedge clk);
      check("samerd_second_data", rf_wdata, 32'h2);
      edge_step();
      @(negedge clk);
      check("samerd_idle_busy", 32'(wb_busy), 32'd0);

      // reset mid-flight; ALU request during reset is dropped
      mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hA;
      jal_valid = 1'b1; jal_pc_plus1 = 32'hB;
      alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'hC;
      expect_wr(5'd4, 32'hA);
      edge_step();
      mem_valid = 1'b0; jal_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("midrst_pre_addr", 32'(rf_waddr), 32'd4);
      edge_step();
      reset = 1'b0; alu_valid = 1'b0;
      @(negedge clk);
      check("midrst_we",        32'(rf_we),     32'd0);
      check("midrst_busy",      32'(wb_busy),   32'd0);
      check("midrst_waddr",     32'(rf_waddr),  32'd0);
      check("midrst_wdata",     rf_wdata,       32'd0);
      check("midrst_alu_ready", 32'(alu_ready), 32'd1);
      check("midrst_jal_ready", 32'(jal_ready), 32'd1);
      repeat (3) edge_step();
      @(negedge clk);
      check("midrst_busy_later", 32'(wb_busy), 32'd0);
      check("sb_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
